// File: rtl/median_pkg.sv
// Shared types and helpers for the 3x3 streaming median filter.
//   PIX_W / pix_t : pixel width and pixel type (unsigned)
//   MED_LAT       : accept-to-output latency in enabled cycles
//   cmp_swap      : compare-exchange, returns {lo, hi}
//   med3          : median of three built from cmp_swap
package median_pkg;
  localparam int MED_LAT = 4;
  localparam int PIX_W   = 8;

  typedef logic [PIX_W-1:0] pix_t;

  typedef struct packed {
    pix_t lo;
    pix_t hi;
  } pair_t;

  function automatic pair_t cmp_swap(input pix_t a, input pix_t b);
    pair_t p;
    if (a < b) begin
      p.lo = a;
      p.hi = b;
    end else begin
      p.lo = b;
      p.hi = a;
    end
    return p;
  endfunction

  // med3 = max(min(a,b), min(max(a,b), c))
  function automatic pix_t med3(input pix_t a, input pix_t b, input pix_t c);
    pair_t ab;
    pair_t hc;
    pair_t fin;
    ab  = cmp_swap(a, b);
    hc  = cmp_swap(ab.hi, c);
    fin = cmp_swap(ab.lo, hc.lo);
    return fin.hi;
  endfunction
endpackage

// File: rtl/median9_pipe.sv
// Two-stage pruned median-of-9 network.
//   clk, rst_n      : clock, synchronous active-low reset (clears valids/flags)
//   en_i            : pipeline advance enable
//   vld_i/eol_i/eof_i : sideband travelling with the window
//   pix_i[9]        : window, row-major (0..2 top row, 6..8 bottom row)
//   med_o           : median of the stage-2 registers (combinational)
//   vld_o/eol_o/eof_o : sideband aligned with med_o
// Stage 1 sorts each row; stage 2 keeps max of row minima, median of row
// medians and min of row maxima; the median of those three is the median of 9.
module median9_pipe
  import median_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic vld_i,
  input  logic eol_i,
  input  logic eof_i,
  input  pix_t pix_i [9],
  output pix_t med_o,
  output logic vld_o,
  output logic eol_o,
  output logic eof_o
);
  pix_t lo_d  [3];
  pix_t mid_d [3];
  pix_t hi_d  [3];
  pix_t lo_q  [3];
  pix_t mid_q [3];
  pix_t hi_q  [3];
  logic s1_vld_q, s1_eol_q, s1_eof_q;

  pix_t lomax_d, midmed_d, himin_d;
  pix_t lomax_q, midmed_q, himin_q;
  logic s2_vld_q, s2_eol_q, s2_eof_q;

  always_comb begin : s1_net
    pair_t p1;
    pair_t p2;
    pair_t p3;
    for (int r = 0; r < 3; r++) begin
      p1       = cmp_swap(pix_i[3*r], pix_i[3*r+1]);
      p2       = cmp_swap(p1.hi, pix_i[3*r+2]);
      p3       = cmp_swap(p1.lo, p2.lo);
      lo_d[r]  = p3.lo;
      mid_d[r] = p3.hi;
      hi_d[r]  = p2.hi;
    end
  end

  always_comb begin : s2_net
    pair_t a;
    pair_t b;
    a        = cmp_swap(lo_q[0], lo_q[1]);
    b        = cmp_swap(a.hi, lo_q[2]);
    lomax_d  = b.hi;
    a        = cmp_swap(hi_q[0], hi_q[1]);
    b        = cmp_swap(a.lo, hi_q[2]);
    himin_d  = b.lo;
    midmed_d = med3(mid_q[0], mid_q[1], mid_q[2]);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_vld_q <= 1'b0;
      s1_eol_q <= 1'b0;
      s1_eof_q <= 1'b0;
      s2_vld_q <= 1'b0;
      s2_eol_q <= 1'b0;
      s2_eof_q <= 1'b0;
    end else if (en_i) begin
      s1_vld_q <= vld_i;
      s1_eol_q <= eol_i;
      s1_eof_q <= eof_i;
      lo_q     <= lo_d;
      mid_q    <= mid_d;
      hi_q     <= hi_d;
      s2_vld_q <= s1_vld_q;
      s2_eol_q <= s1_eol_q;
      s2_eof_q <= s1_eof_q;
      lomax_q  <= lomax_d;
      midmed_q <= midmed_d;
      himin_q  <= himin_d;
    end
  end

  assign med_o = med3(lomax_q, midmed_q, himin_q);
  assign vld_o = s2_vld_q;
  assign eol_o = s2_eol_q;
  assign eof_o = s2_eof_q;
endmodule

// File: rtl/median3x3_stream.sv
// Streaming 3x3 median filter, one pixel per clock, valid/ready on both sides.
//   clk, rst_n              : clock, synchronous active-low reset
//   cfg_bypass              : frame-wide centre-pixel bypass, latched on the sof beat
//   in_valid/in_ready/in_data/in_sof : raster pixel input
//   out_valid/out_ready/out_data     : interior median output
//   out_eol / out_eof       : last interior pixel of a line / of a frame
// Accepted pixels write lb0 while the displaced lb0 entry moves to lb1, so the
// two RAMs always hold the previous two lines at the current column.
module median3x3_stream
  import median_pkg::*;
#(
  parameter int DATA_W = PIX_W,
  parameter int IMG_W  = 100,
  parameter int IMG_H  = 100
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_bypass,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_eol,
  output logic              out_eof
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic          en, accept;
  logic [CW-1:0] col_q, col_d, col_eff;
  logic [RW-1:0] row_q, row_d, row_eff;
  logic          byp_q, byp_eff;
  pix_t          pix_in, lb0_rd, lb1_rd;
  pix_t          lb0_mem [IMG_W];
  pix_t          lb1_mem [IMG_W];
  pix_t          win_q [3][3];
  logic          w_vld_q, w_eol_q, w_eof_q, w_byp_q;
  pix_t          net_pix [9];
  pix_t          p_med;
  logic          p_vld, p_eol, p_eof;
  logic          out_valid_q, out_eol_q, out_eof_q;
  pix_t          out_data_q;

  assign en       = !out_valid_q || out_ready;
  assign in_ready = en;
  assign accept   = in_valid && en;
  assign pix_in   = in_data;

  // An accepted sof restarts the raster regardless of where the counters are.
  assign col_eff = in_sof ? '0 : col_q;
  assign row_eff = in_sof ? '0 : row_q;
  assign byp_eff = in_sof ? cfg_bypass : byp_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (accept) begin
      if (col_eff == COL_LAST) begin
        col_d = '0;
        row_d = (row_eff == ROW_LAST) ? '0 : row_eff + 1'b1;
      end else begin
        col_d = col_eff + 1'b1;
        row_d = row_eff;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col_q <= '0;
      row_q <= '0;
      byp_q <= 1'b0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      if (accept && in_sof) byp_q <= cfg_bypass;
    end
  end

  assign lb0_rd = lb0_mem[col_eff];
  assign lb1_rd = lb1_mem[col_eff];

  always_ff @(posedge clk) begin
    if (accept) begin
      lb0_mem[col_eff] <= pix_in;
      lb1_mem[col_eff] <= lb0_rd;
    end
  end

  // Window columns shift left; column 2 is the newest (row-2, row-1, row).
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < 3; r++) begin
        win_q[r][0] <= win_q[r][1];
        win_q[r][1] <= win_q[r][2];
      end
      win_q[0][2] <= lb1_rd;
      win_q[1][2] <= lb0_rd;
      win_q[2][2] <= pix_in;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_vld_q <= 1'b0;
      w_eol_q <= 1'b0;
      w_eof_q <= 1'b0;
      w_byp_q <= 1'b0;
    end else if (en) begin
      w_vld_q <= accept && (row_eff >= RW'(2)) && (col_eff >= CW'(2));
      w_eol_q <= (col_eff == COL_LAST);
      w_eof_q <= (col_eff == COL_LAST) && (row_eff == ROW_LAST);
      w_byp_q <= byp_eff;
    end
  end

  // Bypass feeds the centre into all nine taps: its median is the centre itself,
  // and the choice stays attached to the window as it travels down the pipe.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      net_pix[i] = w_byp_q ? win_q[1][1] : win_q[i/3][i%3];
    end
  end

  median9_pipe u_net (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (en),
    .vld_i (w_vld_q),
    .eol_i (w_eol_q),
    .eof_i (w_eof_q),
    .pix_i (net_pix),
    .med_o (p_med),
    .vld_o (p_vld),
    .eol_o (p_eol),
    .eof_o (p_eof)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_eol_q   <= 1'b0;
      out_eof_q   <= 1'b0;
      out_data_q  <= '0;
    end else if (en) begin
      out_valid_q <= p_vld;
      out_eol_q   <= p_vld && p_eol;
      out_eof_q   <= p_vld && p_eof;
      if (p_vld) out_data_q <= p_med;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_eol   = out_eol_q;
  assign out_eof   = out_eof_q;
endmodule
